// File: rtl/cdb_arbiter_if.sv
// Result-source and CDB broadcast signals for the CDB arbiter.
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_arbiter_if #(
  parameter int unsigned ROB_W = 4
);
  logic             alu_valid;
  logic [ROB_W-1:0] alu_rob_id;
  logic [31:0]      alu_value;
  logic [31:0]      alu_new_pc;
  logic             lsb_valid;
  logic [ROB_W-1:0] lsb_rob_id;
  logic [31:0]      lsb_value;
  logic             alu_stall;
  logic             lsb_stall;
  logic             cdb_valid;
  logic             cdb_src;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_value;
  logic [31:0]      cdb_new_pc;
  logic             overflow_err;

  modport master (
    output alu_valid, alu_rob_id, alu_value, alu_new_pc,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  alu_stall, lsb_stall,
    input  cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_new_pc,
    input  overflow_err
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_value, alu_new_pc,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output alu_stall, lsb_stall,
    output cdb_valid, cdb_src, cdb_rob_id, cdb_value, cdb_new_pc,
    output overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Merges ALU and LSB results onto one registered CDB broadcast per cycle,
// with a small per-source FIFO and round-robin resolution of contention.
module cdb_arbiter #(
  parameter int unsigned ROB_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          rob_clear,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSB = 1'b1;

  logic [ROB_W-1:0] alu_rob_mem [DEPTH];
  logic [31:0]      alu_val_mem [DEPTH];
  logic [31:0]      alu_pc_mem  [DEPTH];
  logic [ROB_W-1:0] lsb_rob_mem [DEPTH];
  logic [31:0]      lsb_val_mem [DEPTH];

  logic [PTR_W-1:0] alu_rd_ptr, alu_wr_ptr, lsb_rd_ptr, lsb_wr_ptr;
  logic [CNT_W-1:0] alu_cnt, lsb_cnt;
  logic             last_grant;
  logic             overflow_q;
  logic             cdb_valid_q, cdb_src_q;
  logic [ROB_W-1:0] cdb_rob_q;
  logic [31:0]      cdb_val_q, cdb_pc_q;

  logic             alu_empty_c, lsb_empty_c, alu_full_c, lsb_full_c;
  logic             alu_cand_c, lsb_cand_c;
  logic [ROB_W-1:0] alu_head_rob_c, lsb_head_rob_c;
  logic [31:0]      alu_head_val_c, alu_head_pc_c, lsb_head_val_c;
  logic             grant_valid_c, grant_src_c, tie_c;
  logic             alu_pop_c, lsb_pop_c, alu_byp_c, lsb_byp_c;
  logic             alu_wr_c, lsb_wr_c, alu_drop_c, lsb_drop_c;

  // Candidate per source: queued head first, otherwise the live input.
  assign alu_empty_c    = (alu_cnt == '0);
  assign lsb_empty_c    = (lsb_cnt == '0);
  assign alu_full_c     = (alu_cnt == CNT_W'(DEPTH));
  assign lsb_full_c     = (lsb_cnt == CNT_W'(DEPTH));
  assign alu_cand_c     = !alu_empty_c || bus.alu_valid;
  assign lsb_cand_c     = !lsb_empty_c || bus.lsb_valid;
  assign alu_head_rob_c = alu_empty_c ? bus.alu_rob_id : alu_rob_mem[alu_rd_ptr];
  assign alu_head_val_c = alu_empty_c ? bus.alu_value  : alu_val_mem[alu_rd_ptr];
  assign alu_head_pc_c  = alu_empty_c ? bus.alu_new_pc : alu_pc_mem[alu_rd_ptr];
  assign lsb_head_rob_c = lsb_empty_c ? bus.lsb_rob_id : lsb_rob_mem[lsb_rd_ptr];
  assign lsb_head_val_c = lsb_empty_c ? bus.lsb_value  : lsb_val_mem[lsb_rd_ptr];
  assign tie_c          = alu_cand_c && lsb_cand_c;

  always_comb begin
    grant_valid_c = 1'b0;
    grant_src_c   = GRANT_ALU;
    if (tie_c) begin
      grant_valid_c = 1'b1;
      grant_src_c   = ~last_grant;
    end else if (alu_cand_c) begin
      grant_valid_c = 1'b1;
      grant_src_c   = GRANT_ALU;
    end else if (lsb_cand_c) begin
      grant_valid_c = 1'b1;
      grant_src_c   = GRANT_LSB;
    end
  end

  // Queue bookkeeping: a bypassed input is consumed, anything else is pushed.
  assign alu_pop_c  = grant_valid_c && (grant_src_c == GRANT_ALU) && !alu_empty_c;
  assign lsb_pop_c  = grant_valid_c && (grant_src_c == GRANT_LSB) && !lsb_empty_c;
  assign alu_byp_c  = grant_valid_c && (grant_src_c == GRANT_ALU) && alu_empty_c;
  assign lsb_byp_c  = grant_valid_c && (grant_src_c == GRANT_LSB) && lsb_empty_c;
  assign alu_drop_c = bus.alu_valid && !alu_byp_c && alu_full_c && !alu_pop_c;
  assign lsb_drop_c = bus.lsb_valid && !lsb_byp_c && lsb_full_c && !lsb_pop_c;
  assign alu_wr_c   = bus.alu_valid && !alu_byp_c && !alu_drop_c;
  assign lsb_wr_c   = bus.lsb_valid && !lsb_byp_c && !lsb_drop_c;

  always_ff @(posedge clk_in) begin
    if (rdy_in && !rob_clear) begin
      if (alu_wr_c) begin
        alu_rob_mem[alu_wr_ptr] <= bus.alu_rob_id;
        alu_val_mem[alu_wr_ptr] <= bus.alu_value;
        alu_pc_mem[alu_wr_ptr]  <= bus.alu_new_pc;
      end
      if (lsb_wr_c) begin
        lsb_rob_mem[lsb_wr_ptr] <= bus.lsb_rob_id;
        lsb_val_mem[lsb_wr_ptr] <= bus.lsb_value;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_rd_ptr  <= '0;
      alu_wr_ptr  <= '0;
      lsb_rd_ptr  <= '0;
      lsb_wr_ptr  <= '0;
      alu_cnt     <= '0;
      lsb_cnt     <= '0;
      last_grant  <= GRANT_LSB;
      overflow_q  <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_val_q   <= '0;
      cdb_pc_q    <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        alu_rd_ptr  <= '0;
        alu_wr_ptr  <= '0;
        lsb_rd_ptr  <= '0;
        lsb_wr_ptr  <= '0;
        alu_cnt     <= '0;
        lsb_cnt     <= '0;
        cdb_valid_q <= 1'b0;
      end else begin
        if (alu_pop_c) alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
        if (alu_wr_c)  alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
        if (lsb_pop_c) lsb_rd_ptr <= lsb_rd_ptr + PTR_W'(1);
        if (lsb_wr_c)  lsb_wr_ptr <= lsb_wr_ptr + PTR_W'(1);
        if (alu_wr_c && !alu_pop_c)      alu_cnt <= alu_cnt + CNT_W'(1);
        else if (!alu_wr_c && alu_pop_c) alu_cnt <= alu_cnt - CNT_W'(1);
        if (lsb_wr_c && !lsb_pop_c)      lsb_cnt <= lsb_cnt + CNT_W'(1);
        else if (!lsb_wr_c && lsb_pop_c) lsb_cnt <= lsb_cnt - CNT_W'(1);
        if (tie_c) last_grant <= grant_src_c;
        if (alu_drop_c || lsb_drop_c) overflow_q <= 1'b1;
        cdb_valid_q <= grant_valid_c;
        if (grant_valid_c) begin
          cdb_src_q <= grant_src_c;
          if (grant_src_c == GRANT_LSB) begin
            cdb_rob_q <= lsb_head_rob_c;
            cdb_val_q <= lsb_head_val_c;
            cdb_pc_q  <= '0;
          end else begin
            cdb_rob_q <= alu_head_rob_c;
            cdb_val_q <= alu_head_val_c;
            cdb_pc_q  <= alu_head_pc_c;
          end
        end
      end
    end
  end

  // Stall leaves room for the one result already in flight.
  assign bus.alu_stall    = (alu_cnt >= CNT_W'(DEPTH - 1));
  assign bus.lsb_stall    = (lsb_cnt >= CNT_W'(DEPTH - 1));
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.cdb_rob_id   = cdb_rob_q;
  assign bus.cdb_value    = cdb_val_q;
  assign bus.cdb_new_pc   = cdb_pc_q;
  assign bus.overflow_err = overflow_q;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the RS/ALU result port and the LSB result port.
- Today both sources broadcast independently, and every consumer (RS, LSB, ROB) must snoop two buses. This block merges them into one registered broadcast per cycle.
- Each source has a small FIFO. Round-robin arbitration resolves contention, and stall outputs throttle the source before its FIFO can overflow.
- Sits between the ALU/LSB outputs and every CDB consumer.

Parameters:
- ROB_W, 4, width of ROB index.
- DEPTH, 4, entries per source FIFO (power of two, ≥2).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes all state.
- rob_clear  input  1  misprediction flush.
- alu_valid  input  1  ALU result this cycle.
- alu_rob_id  input  ROB_W  ROB tag of ALU result.
- alu_value  input  32  ALU result.
- alu_new_pc  input  32  jalr target from ALU.
- lsb_valid  input  1  LSB load result this cycle.
- lsb_rob_id  input  ROB_W  ROB tag of LSB result.
- lsb_value  input  32  load data.
- alu_stall  output  1  RS must not issue next cycle.
- lsb_stall  output  1  LSB must not complete next cycle.
- cdb_valid  output  1  broadcast valid.
- cdb_src  output  1  0 = ALU, 1 = LSB.
- cdb_rob_id  output  ROB_W  broadcast tag.
- cdb_value  output  32  broadcast value.
- cdb_new_pc  output  32  jalr target; 0 when cdb_src = 1.
- overflow_err  output  1  sticky; a push was dropped.

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - Both FIFOs empty, counts 0.
  - cdb_valid = 0; cdb_src, cdb_rob_id, cdb_value, cdb_new_pc = 0.
  - overflow_err = 0.
  - last_grant = 1 (LSB), so the ALU wins the first tie.
  - Reset mid-operation discards all queued results.
- rdy_in = 0: no state changes; outputs hold; inputs are ignored (upstream is frozen too).
- Candidates, per source each cycle:
  - FIFO head if the FIFO is non-empty; otherwise the incoming result if its valid is high (bypass).
  - Queued entries always precede new input, so per-source order is strictly preserved.
- Grant:
  - One candidate only: that source wins.
  - Both: the source ≠ last_grant wins.
  - last_grant updates only when a tie is resolved.
- On the clock edge:
  - The granted candidate is loaded into the cdb_* registers and cdb_valid = 1.
  - No candidate: cdb_valid = 0, other cdb_* hold.
  - Latency with no contention: input at edge t appears on the CDB after edge t+1 (exactly 1 cycle).
- FIFO update per source:
  - Pop if the FIFO head was granted.
  - Push the incoming result if it is valid and was not bypassed directly to the CDB.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
- Stall:
  - alu_stall = (alu_count ≥ DEPTH−1); lsb_stall likewise. Both are combinational from registered counts.
  - This guarantees room for the one result already in flight when the stall is observed.
- Overflow: a push with count = DEPTH and no same-cycle pop is dropped and sets overflow_err, which stays set until reset.
- rob_clear = 1 (with rdy_in = 1):
  - Both FIFOs are emptied and cdb_valid = 0 after the edge.
  - Same-cycle inputs are dropped; last_grant is unchanged.
  - rob_clear has priority over all pushes and grants.
- cdb_new_pc is 0 for LSB grants and alu_new_pc for ALU grants.
- The output is registered; no combinational path runs from inputs to cdb_*.

Test Plan:
- Single ALU result:
  - Stimulus: alu_valid = 1, rob_id = 3, value = 0x2A, new_pc = 0x100 for one cycle.
  - Response: the next cycle shows cdb_valid = 1, src = 0, rob_id = 3, value = 0x2A, new_pc = 0x100; the cycle after, cdb_valid = 0.
- Simultaneous sources:
  - Stimulus: ALU(id 1, 0x11) and LSB(id 2, 0x22) in the same cycle after reset.
  - Response: CDB shows ALU id 1, then LSB id 2 on consecutive cycles; new_pc = 0 on the LSB beat.
- Sustained contention:
  - Stimulus: both sources valid for 4 cycles.
  - Response: the CDB strictly alternates ALU, LSB, ALU, …; 8 beats total in order; per-source ids are never reordered.
- Stall threshold (DEPTH = 4):
  - Stimulus: LSB valid every cycle while the ALU is also saturating.
  - Response: lsb_stall rises when lsb_count reaches 3; the bench stops LSB input and sees no overflow_err.
  - Forcing a 5th push at count 4 sets overflow_err = 1 and keeps it set.
- Flush:
  - Stimulus: queue 3 ALU entries, then pulse rob_clear together with a new lsb_valid.
  - Response: next cycle cdb_valid = 0, both stalls low, and no queued entry or the dropped LSB result ever appears.
- Freeze and reset:
  - Stimulus: hold rdy_in = 0 for 5 cycles with 2 entries queued.
  - Response: the CDB holds and counts are unchanged; after rdy_in returns, both entries drain in order.
  - Asserting rst_in low asynchronously mid-drain immediately forces cdb_valid = 0 and empty FIFOs.
